// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encodings, LED bit positions and default tick
// lengths for the alarm_controller slice.
package alarm_pkg;

   typedef enum logic [2:0] {
      ST_DISARMED    = 3'd0,
      ST_ARM_PENDING = 3'd1,
      ST_ARMED       = 3'd2,
      ST_ENTRY_DELAY = 3'd3,
      ST_TRIGGERED   = 3'd4
   } state_e;

   localparam int LED_DISARMED = 7;
   localparam int LED_ARMED    = 6;
   localparam int LED_ZONE_LSB = 2;
   localparam int LED_STROBE   = 1;
   localparam int LED_TRIG     = 0;

   localparam int DEF_EXIT_TICKS  = 100;
   localparam int DEF_ENTRY_TICKS = 50;
   localparam int DEF_STROBE_HALF = 2;

endpackage

// File: rtl/alarm_input_sync.sv
// alarm_input_sync: 2-flop synchronizer, optionally followed by a
// rising-edge detector (RISE=1) that emits a one-edge press pulse.
// Ports: CLK_100ms clock, SYS_RST async active-high reset,
//        i_d asynchronous levels, o_q synced level or press pulse.
module alarm_input_sync #(
   parameter int W    = 1,
   parameter bit RISE = 1'b0
) (
   input  logic         CLK_100ms,
   input  logic         SYS_RST,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_s1;
   logic [W-1:0] r_s2;

   always_ff @(posedge CLK_100ms or posedge SYS_RST) begin
      if (SYS_RST) begin
         r_s1 <= '0;
         r_s2 <= '0;
      end else begin
         r_s1 <= i_d;
         r_s2 <= r_s1;
      end
   end

   generate
      if (RISE) begin : g_rise
         logic [W-1:0] r_prev;
         logic [W-1:0] r_seen;
         logic         r_vld;

         // r_seen only arms once a genuine low has been sampled after
         // reset, so a key held through reset never fakes a press.
         always_ff @(posedge CLK_100ms or posedge SYS_RST) begin
            if (SYS_RST) begin
               r_prev <= '0;
               r_seen <= '0;
               r_vld  <= 1'b0;
            end else begin
               r_prev <= r_s2;
               r_vld  <= 1'b1;
               r_seen <= r_seen | (~r_s1 & {W{r_vld}});
            end
         end

         assign o_q = r_s2 & ~r_prev & r_seen;
      end else begin : g_lvl
         assign o_q = r_s2;
      end
   endgenerate

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: exit-delay / entry-delay / trigger sequencer with LED
// status decode. ENTRY_DELAY exists only when ALARM_ENTRY_DELAY_EN is set.
// Ports: CLK_100ms, SYS_RST (async, active-high), panic_key, arm_key,
//        zone_sensor[2:0] in; led[7:0] status, state[2:0] debug out.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int EXIT_TICKS  = DEF_EXIT_TICKS,
   parameter int ENTRY_TICKS = DEF_ENTRY_TICKS,
   parameter int STROBE_HALF = DEF_STROBE_HALF
) (
   input  logic       CLK_100ms,
   input  logic       SYS_RST,
   input  logic       panic_key,
   input  logic       arm_key,
   input  logic [2:0] zone_sensor,
   output logic [7:0] led,
   output logic [2:0] state
);

   localparam logic [6:0] EXIT_LAST  = 7'(EXIT_TICKS - 1);
   localparam logic [6:0] ENTRY_LAST = 7'(ENTRY_TICKS - 1);
   localparam logic [6:0] SH_LAST    = 7'(STROBE_HALF - 1);

   logic [1:0] w_keys;
   logic [2:0] w_zone;
   logic       w_panic;
   logic       w_arm;

   state_e     r_state;
   state_e     w_next;
   logic [6:0] r_timer;
   logic [6:0] r_scnt;
   logic       r_strobe;
   logic [2:0] r_zmem;
   logic [2:0] w_zmem_nxt;
   logic [6:0] w_limit;
   logic       w_tdone;
   logic       w_entry;
   logic       w_flash;

   alarm_input_sync #(.W(2), .RISE(1'b1)) u_keys (
      .CLK_100ms (CLK_100ms),
      .SYS_RST   (SYS_RST),
      .i_d       ({panic_key, arm_key}),
      .o_q       (w_keys)
   );

   alarm_input_sync #(.W(3), .RISE(1'b0)) u_zones (
      .CLK_100ms (CLK_100ms),
      .SYS_RST   (SYS_RST),
      .i_d       (zone_sensor),
      .o_q       (w_zone)
   );

   assign w_panic = w_keys[1];
   assign w_arm   = w_keys[0];

   assign w_limit = (r_state == ST_ENTRY_DELAY) ? ENTRY_LAST : EXIT_LAST;
   assign w_tdone = (r_timer == w_limit);
   assign w_entry = (w_next != r_state);
   assign w_flash = (r_state == ST_ARM_PENDING) ||
                    (r_state == ST_TRIGGERED);

   always_comb begin
      w_next     = r_state;
      w_zmem_nxt = r_zmem;
      case (r_state)
         ST_DISARMED: begin
            if (w_arm && (w_zone == 3'b000))
               w_next = ST_ARM_PENDING;
         end
         ST_ARM_PENDING: begin
            if (w_arm)        w_next = ST_DISARMED;
            else if (w_tdone) w_next = ST_ARMED;
         end
         ST_ARMED: begin
            if (w_arm) begin
               w_next = ST_DISARMED;
            end else if (|w_zone) begin
`ifdef ALARM_ENTRY_DELAY_EN
               w_next = ST_ENTRY_DELAY;
`else
               w_next = ST_TRIGGERED;
`endif
               w_zmem_nxt = w_zone;
            end
         end
         ST_ENTRY_DELAY: begin
            if (w_arm) begin
               w_next = ST_DISARMED;
            end else begin
               w_zmem_nxt = r_zmem | w_zone;
               if (w_tdone) w_next = ST_TRIGGERED;
            end
         end
         ST_TRIGGERED: begin
            if (w_arm) w_next = ST_DISARMED;
            else       w_zmem_nxt = r_zmem | w_zone;
         end
         default: w_next = ST_DISARMED;
      endcase
      // Panic overrides everything and must not latch new zones.
      if (w_panic) begin
         w_next     = ST_TRIGGERED;
         w_zmem_nxt = r_zmem;
      end
      if (w_next == ST_DISARMED) w_zmem_nxt = 3'b000;
   end

   always_ff @(posedge CLK_100ms or posedge SYS_RST) begin
      if (SYS_RST) begin
         r_state <= ST_DISARMED;
         r_zmem  <= 3'b000;
         r_timer <= 7'd0;
      end else begin
         r_state <= w_next;
         r_zmem  <= w_zmem_nxt;
         if (w_entry)               r_timer <= 7'd0;
         else if (r_timer != 7'h7f) r_timer <= r_timer + 7'd1;
      end
   end

   // Strobe toggler shared by the ARM_PENDING flash and TRIGGERED strobe.
   always_ff @(posedge CLK_100ms or posedge SYS_RST) begin
      if (SYS_RST) begin
         r_strobe <= 1'b0;
         r_scnt   <= 7'd0;
      end else if (w_entry) begin
         r_strobe <= (w_next == ST_ARM_PENDING) ||
                     (w_next == ST_TRIGGERED);
         r_scnt   <= 7'd0;
      end else if (w_flash) begin
         if (r_scnt == SH_LAST) begin
            r_strobe <= ~r_strobe;
            r_scnt   <= 7'd0;
         end else begin
            r_scnt   <= r_scnt + 7'd1;
         end
      end
   end

   always_comb begin
      led = 8'h00;
      case (r_state)
         ST_DISARMED: begin
            led[LED_DISARMED]      = 1'b1;
            led[LED_ZONE_LSB +: 3] = w_zone;
         end
         ST_ARM_PENDING: begin
            led[LED_ARMED] = r_strobe;
         end
         ST_ARMED: begin
            led[LED_ARMED] = 1'b1;
         end
         ST_ENTRY_DELAY: begin
            led[LED_ARMED]         = 1'b1;
            led[LED_ZONE_LSB +: 3] = r_zmem;
         end
         ST_TRIGGERED: begin
            led[LED_ARMED]         = 1'b1;
            led[LED_ZONE_LSB +: 3] = r_zmem;
            led[LED_STROBE]        = r_strobe;
            led[LED_TRIG]          = 1'b1;
         end
         default: led = 8'h00;
      endcase
   end

   assign state = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed scenarios plus randomized key/zone traffic
// checked edge by edge against an input-history reference model.
`timescale 1ns/1ps
module tb_alarm_controller;

   localparam int EXIT  = 100;
   localparam int ENTRY = 50;
   localparam int SH    = 2;
   localparam int MAXH  = 20000;
`ifdef ALARM_ENTRY_DELAY_EN
   localparam bit ED_EN = 1'b1;
`else
   localparam bit ED_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pk  = 1'b0;
   logic       ak  = 1'b0;
   logic [2:0] zs  = 3'b000;
   logic [7:0] led;
   logic [2:0] state;

   alarm_controller #(
      .EXIT_TICKS  (EXIT),
      .ENTRY_TICKS (ENTRY),
      .STROBE_HALF (SH)
   ) dut (
      .CLK_100ms   (clk),
      .SYS_RST     (rst),
      .panic_key   (pk),
      .arm_key     (ak),
      .zone_sensor (zs),
      .led         (led),
      .state       (state)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Input history by edge index; only samples at or after 'first'
   // (first edge after reset release) are meaningful.
   int         n     = 0;
   int         first = 1;
   logic       h_a [MAXH];
   logic       h_p [MAXH];
   logic [2:0] h_z [MAXH];

   // Model: mode 0..4 = DISARMED..TRIGGERED, entry edge, latched zones.
   int         m_mode = 0;
   int         m_ent  = 0;
   logic [2:0] m_zmem = 3'b000;

   // A press decided at edge e is a 0->1 between samples e-3 and e-2.
   function automatic logic press_of(input bit pan, input int e);
      logic cur, prv;
      if (e - 3 < first) return 1'b0;
      cur = pan ? h_p[e-2] : h_a[e-2];
      prv = pan ? h_p[e-3] : h_a[e-3];
      return cur & ~prv;
   endfunction

   function automatic logic [2:0] zone_at(input int j);
      return (j >= first) ? h_z[j] : 3'b000;
   endfunction

   function automatic logic m_strobe();
      return (((n - m_ent) / SH) % 2) == 0;
   endfunction

   function automatic logic [7:0] m_led();
      logic [7:0] v;
      case (m_mode)
         0: v = 8'h80 | {3'b000, zone_at(n - 1), 2'b00};
         1: v = {1'b0, m_strobe(), 6'b000000};
         2: v = 8'h40;
         3: v = 8'h40 | {3'b000, m_zmem, 2'b00};
         default: v = {3'b010, m_zmem, m_strobe(), 1'b1};
      endcase
      return v;
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_zmem = 3'b000;
      m_ent  = n;
      first  = n + 1;
   endtask

   task automatic tick();
      int         nm;
      logic       p, a;
      logic [2:0] z, nz;
      @(posedge clk);
      n++;
      if (n >= MAXH) begin
         $display("FAIL history_bound n=%0d limit=%0d", n, MAXH);
         $fatal(1, "history exhausted");
      end
      h_a[n] = ak;
      h_p[n] = pk;
      h_z[n] = zs;
      p  = press_of(1'b1, n);
      a  = press_of(1'b0, n);
      z  = zone_at(n - 2);
      nm = m_mode;
      nz = m_zmem;
      if (p) begin
         nm = 4;
      end else if (a && m_mode != 0) begin
         nm = 0;
      end else begin
         case (m_mode)
            0: if (a && z == 3'b000) nm = 1;
            1: if (n - m_ent == EXIT) nm = 2;
            2: if (z != 3'b000) begin
                  nm = ED_EN ? 3 : 4;
                  nz = z;
               end
            3: begin
                  nz = nz | z;
                  if (n - m_ent == ENTRY) nm = 4;
               end
            default: nz = nz | z;
         endcase
      end
      if (nm == 0) nz = 3'b000;
      if (nm != m_mode) m_ent = n;
      m_mode = nm;
      m_zmem = nz;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      n_tests++;
      if (led !== 8'h80 || state !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_async led=%h state=%0d want led=80 state=0",
                  led, state);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      ak = 1'b0; pk = 1'b0; zs = 3'b000;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         tick();
         n_tests++;
         if (led !== 8'h80 || state !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_idle i=%0d led=%h state=%0d want 80/0",
                     i, led, state);
         end
      end
   endtask

   task automatic test_arm_sequence();
      bit saw0 = 1'b0;
      bit saw1 = 1'b0;
      int flips = 0;
      logic prev_s;
      zs = 3'b000;
      ak = 1'b1;
      for (int i = 0; i < 105; i++) begin
         if (i == 3) ak = 1'b0;
         tick();
         if (state == 3'd1) begin
            if (led[6]) saw1 = 1'b1;
            else        saw0 = 1'b1;
         end
         n_tests++;
         if (state !== 3'(m_mode) || led !== m_led()) begin
            n_fail++;
            $display("FAIL arm_seq i=%0d state=%0d led=%h want %0d/%h",
                     i, state, led, m_mode, m_led());
         end
      end
      n_tests++;
      if (state !== 3'd2 || led !== 8'h40 || !(saw0 && saw1)) begin
         n_fail++;
         $display("FAIL armed_reached state=%0d led=%h flash=%0d%0d want 2/40/11",
                  state, led, saw0, saw1);
      end
      zs = 3'b010;
      repeat (3) tick();
      n_tests++;
`ifdef ALARM_ENTRY_DELAY_EN
      if (state !== 3'd3 || led !== 8'h48) begin
         n_fail++;
         $display("FAIL entry_delay state=%0d led=%h want 3/48", state, led);
      end
`else
      if (state !== 3'd4 || led[4:2] !== 3'b010 || led[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL direct_trig state=%0d led=%h want 4/zone 010",
                  state, led);
      end
`endif
      zs = 3'b000;
      for (int i = 0; i < 55; i++) begin
         tick();
         n_tests++;
         if (state !== 3'(m_mode) || led !== m_led()) begin
            n_fail++;
            $display("FAIL entry_run i=%0d state=%0d led=%h want %0d/%h",
                     i, state, led, m_mode, m_led());
         end
      end
      n_tests++;
      if (state !== 3'd4 || led[0] !== 1'b1 || led[4:2] !== 3'b010) begin
         n_fail++;
         $display("FAIL triggered state=%0d led=%h want 4 trig zone 010",
                  state, led);
      end
      prev_s = led[1];
      for (int i = 0; i < 8; i++) begin
         tick();
         if (led[1] !== prev_s) flips++;
         prev_s = led[1];
      end
      n_tests++;
      if (flips != 4) begin
         n_fail++;
         $display("FAIL strobe_rate flips=%0d over 8 edges want 4", flips);
      end
      ak = 1'b1;
      repeat (2) tick();
      ak = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (state !== 3'd0 || led !== 8'h80) begin
         n_fail++;
         $display("FAIL disarm_trig state=%0d led=%h want 0/80", state, led);
      end
   endtask

   task automatic test_zone_block();
      zs = 3'b001;
      repeat (3) tick();
      ak = 1'b1;
      repeat (3) tick();
      ak = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (state !== 3'(m_mode) || led !== m_led()) begin
            n_fail++;
            $display("FAIL zone_block_m i=%0d state=%0d led=%h want %0d/%h",
                     i, state, led, m_mode, m_led());
         end
      end
      n_tests++;
      if (state !== 3'd0 || led !== 8'h84) begin
         n_fail++;
         $display("FAIL zone_block state=%0d led=%h want 0/84", state, led);
      end
      zs = 3'b000;
      repeat (3) tick();
   endtask

   task automatic test_cancel();
      bit saw_trig = 1'b0;
      ak = 1'b1;
      repeat (2) tick();
      ak = 1'b0;
      repeat (EXIT + 5) tick();
      zs = 3'b001;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (state == 3'd4) saw_trig = 1'b1;
         n_tests++;
         if (state !== 3'(m_mode) || led !== m_led()) begin
            n_fail++;
            $display("FAIL cancel_m i=%0d state=%0d led=%h want %0d/%h",
                     i, state, led, m_mode, m_led());
         end
      end
      ak = 1'b1;
      zs = 3'b000;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (state == 3'd4) saw_trig = 1'b1;
      end
      ak = 1'b0;
      n_tests++;
      if (state !== 3'd0 || led !== 8'h80) begin
         n_fail++;
         $display("FAIL cancel state=%0d led=%h want 0/80", state, led);
      end
`ifdef ALARM_ENTRY_DELAY_EN
      n_tests++;
      if (saw_trig) begin
         n_fail++;
         $display("FAIL cancel_no_trig saw_trig=1 want 0");
      end
`endif
      repeat (2) tick();
   endtask

   task automatic test_panic();
      int entries = 0;
      logic [2:0] prev_st;
      prev_st = state;
      pk = 1'b1;
      ak = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (state == 3'd4 && prev_st != 3'd4) entries++;
         prev_st = state;
         n_tests++;
         if (state !== 3'(m_mode) || led !== m_led()) begin
            n_fail++;
            $display("FAIL panic_m i=%0d state=%0d led=%h want %0d/%h",
                     i, state, led, m_mode, m_led());
         end
      end
      n_tests++;
      if (state !== 3'd4 || led[4:2] !== 3'b000 || entries != 1) begin
         n_fail++;
         $display("FAIL panic state=%0d zones=%b entries=%0d want 4/000/1",
                  state, led[4:2], entries);
      end
      pk = 1'b0;
      ak = 1'b0;
      repeat (2) tick();
      ak = 1'b1;
      repeat (2) tick();
      ak = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (state !== 3'd0) begin
         n_fail++;
         $display("FAIL panic_disarm state=%0d want 0", state);
      end
   endtask

   task automatic test_reset_midrun();
      pk = 1'b1;
      repeat (2) tick();
      pk = 1'b0;
      repeat (5) tick();
      ak = 1'b1;
      tick();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_tests++;
         if (state !== 3'd0 || led !== 8'h80) begin
            n_fail++;
            $display("FAIL no_residual i=%0d state=%0d led=%h want 0/80",
                     i, state, led);
         end
      end
      ak = 1'b0;
      repeat (3) tick();
      ak = 1'b1;
      repeat (3) tick();
      n_tests++;
      if (state !== 3'd1 || state !== 3'(m_mode)) begin
         n_fail++;
         $display("FAIL rearm_after_rst state=%0d want 1", state);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 59) == 0) ak = ~ak;
         if ($urandom_range(0, 499) == 0) pk = 1'b1;
         else if (pk && $urandom_range(0, 3) == 0) pk = 1'b0;
         if ($urandom_range(0, 149) == 0)
            zs[$urandom_range(0, 2)] = 1'b1;
         else if (zs != 3'b000 && $urandom_range(0, 19) == 0)
            zs = 3'b000;
         tick();
         n_tests++;
         if (state !== 3'(m_mode) || led !== m_led()) begin
            n_fail++;
            $display("FAIL random i=%0d state=%0d led=%h want %0d/%h",
                     i, state, led, m_mode, m_led());
         end
      end
   endtask

   initial begin
      test_reset();
      test_arm_sequence();
      test_zone_block();
      test_cancel();
      test_panic();
      test_reset_midrun();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
